// File: rtl/seq_det_pkg.sv
// Shared constants for the 11011 detector path: PISO state encodings and the decimal wrap value.
package seq_det_pkg;

  typedef enum logic [1:0] {
    PISO_IDLE  = 2'b01,
    PISO_SHIFT = 2'b10
  } piso_state_e;

  localparam logic [3:0] WORD_CNT_MAX = 4'd9;

endpackage

// File: rtl/seq_piso_sar.sv
// Parallel-in/serial-out stage feeding the 11011 detector, MSB first, with a mod-10 word counter.
// Latency: MSB on ser_out the cycle after acceptance; frame_done one cycle after the last bit.
// Backpressure: din_ready only in IDLE or on the last bit slot. Parity slot under SEQ_PISO_PARITY_EN.
module seq_piso_sar
  import seq_det_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic [3:0]       word_cnt
);

`ifdef SEQ_PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);

  piso_state_e      state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d, load_word;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       word_cnt_q, word_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             last_bit, xfer;

`ifdef SEQ_PISO_PARITY_EN
  assign load_word = {din, ^din};
`else
  assign load_word = din;
`endif

  assign last_bit = (state_q == PISO_SHIFT) && (bit_cnt_q == 4'd0);
  assign xfer     = din_valid && din_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PISO_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PISO_IDLE:  if (xfer) state_d = PISO_SHIFT;
      PISO_SHIFT: if (last_bit && !xfer) state_d = PISO_IDLE;
      default:    state_d = PISO_IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    din_ready = 1'b0;
    ser_valid = 1'b0;
    ser_out   = IDLE_BIT;
    case (state_q)
      PISO_IDLE: begin
        din_ready = reset;
      end
      PISO_SHIFT: begin
        din_ready = reset && last_bit;
        ser_valid = 1'b1;
        ser_out   = shreg_q[NBITS-1];
      end
      default: begin
        din_ready = 1'b0;
      end
    endcase
  end

  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = last_bit;
    word_cnt_d   = word_cnt_q;
    if (xfer) begin
      shreg_d   = load_word;
      bit_cnt_d = LAST_IDX;
    end else if (state_q == PISO_SHIFT) begin
      shreg_d = shreg_q << 1;
      if (!last_bit) bit_cnt_d = bit_cnt_q - 4'd1;
    end
    if (last_bit) begin
      word_cnt_d = (word_cnt_q == WORD_CNT_MAX) ? 4'd0 : word_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q      <= '0;
      bit_cnt_q    <= 4'd0;
      frame_done_q <= 1'b0;
      word_cnt_q   <= 4'd0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign frame_done = frame_done_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_seq_piso_sar.sv
// Bench for seq_piso_sar: vector table, hand sequences and random traffic against a bit-queue model.
module tb_seq_piso_sar;

  localparam int W = 8;
`ifdef SEQ_PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, ser_out, ser_valid, frame_done;
  logic [3:0]   word_cnt;

  seq_piso_sar #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_done(frame_done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a queue of pending serial bits; front is the bit on the wire this cycle.
  typedef struct { bit b; bit last; } sbit_t;
  sbit_t q[$];
  int    m_cnt = 0;
  bit    m_fd  = 0;
  bit    m_acc = 0;

  typedef struct {
    logic [7:0] din;
    logic [8:0] exp_bits;  // stream MSB first, parity bit in [0]
    logic [3:0] exp_cnt;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0;
    m_fd  = 0;
    m_acc = 0;
  endtask

  task automatic model_edge();
    bit    rdy;
    sbit_t s;
    if (!reset) begin
      model_reset();
      return;
    end
    rdy   = (q.size() <= 1);
    m_fd  = 0;
    m_acc = 0;
    if (q.size() > 0) begin
      s = q.pop_front();
      if (s.last) begin
        m_fd  = 1;
        m_cnt = (m_cnt + 1) % 10;
      end
    end
    if (din_valid && rdy) begin
      m_acc = 1;
      for (int k = W - 1; k >= 0; k--) begin
        s.b = din[k];
        s.last = (k == 0) && (NB == W);
        q.push_back(s);
      end
      if (NB != W) begin
        s.b = ^din;
        s.last = 1;
        q.push_back(s);
      end
    end
  endtask

  task automatic check_outputs();
    chk("din_ready",  32'(din_ready),  32'(reset && (q.size() <= 1)));
    chk("ser_valid",  32'(ser_valid),  32'(q.size() > 0));
    chk("ser_out",    32'(ser_out),    32'((q.size() > 0) ? q[0].b : 1'b0));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("word_cnt",   32'(word_cnt),   32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_word(input logic [W-1:0] d);
    int n;
    din = d;
    din_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!m_acc && n < 40);
    if (!m_acc) chk("accept_timeout", 32'(n), 32'(0));
    din_valid = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (!frame_done && n < 40) begin
      step();
      n++;
    end
    chk("fd_seen", 32'(frame_done), 32'(1));
  endtask

  initial begin
    int sv_run, fd1, fd2, cyc;

    vt[0] = '{8'hD8, 9'b110110000, 4'd1};
    vt[1] = '{8'hD9, 9'b110110011, 4'd2};
    vt[2] = '{8'hA5, 9'b101001010, 4'd3};
    vt[3] = '{8'h01, 9'b000000011, 4'd4};

    // Reset held: valid toggling must be ignored.
    #1;
    chk("rst_ready", 32'(din_ready), 32'(0));
    chk("rst_sv",    32'(ser_valid), 32'(0));
    chk("rst_so",    32'(ser_out),   32'(0));
    chk("rst_cnt",   32'(word_cnt),  32'(0));
    for (int i = 0; i < 4; i++) begin
      din_valid = i[0];
      din = 8'hFF;
      step();
    end
    din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("idle_ready", 32'(din_ready), 32'(1));
    check_outputs();

    // Table of single words.
    for (int t = 0; t < 4; t++) begin
      din = vt[t].din;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int k = 0; k < NB; k++) begin
        if (k > 0) step();
        chk("tbl_sv",  32'(ser_valid), 32'(1));
        chk("tbl_bit", 32'(ser_out),   32'(vt[t].exp_bits[8-k]));
      end
      step();
      chk("tbl_fd",  32'(frame_done), 32'(1));
      chk("tbl_cnt", 32'(word_cnt),   32'(vt[t].exp_cnt));
      step();
      chk("tbl_idle", 32'(ser_valid), 32'(0));
    end

    // Back-to-back: two words with valid held, no gap in ser_valid.
    send_word(8'hDB);
    din = 8'h1B;
    din_valid = 1'b1;
    sv_run = 1; fd1 = -1; fd2 = -1; cyc = 0;
    while (cyc < 3 * NB) begin
      step();
      cyc++;
      if (m_acc) din_valid = 1'b0;
      if (ser_valid) sv_run++;
      if (frame_done) begin
        if (fd1 < 0) fd1 = cyc; else if (fd2 < 0) fd2 = cyc;
      end
      if (!ser_valid && !frame_done && fd2 >= 0) break;
    end
    din_valid = 1'b0;
    chk("b2b_run", 32'(sv_run), 32'(2 * NB));
    chk("b2b_gap", 32'(fd2 - fd1), 32'(NB));
    chk("b2b_cnt", 32'(word_cnt), 32'(6));

    // Wrap: clear counter, then ten words of all ones.
    reset = 1'b0;
    #1;
    model_reset();
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send_word(8'hFF);
      wait_fd();
      chk("wrap_cnt", 32'(word_cnt), 32'((i + 1) % 10));
    end
    step();

    // Mid-word reset after three bits.
    send_word(8'hA5);
    step();
    step();
    reset = 1'b0;
    #1;
    model_reset();
    chk("mid_sv",    32'(ser_valid),  32'(0));
    chk("mid_so",    32'(ser_out),    32'(0));
    chk("mid_ready", 32'(din_ready),  32'(0));
    chk("mid_fd",    32'(frame_done), 32'(0));
    chk("mid_cnt",   32'(word_cnt),   32'(0));
    step();
    reset = 1'b1;
    for (int i = 0; i < NB + 2; i++) step();
    chk("mid_cnt_after", 32'(word_cnt), 32'(0));

    // Random traffic; din is held while an offer is pending.
    for (int i = 0; i < 400; i++) begin
      if (!din_valid || m_acc) begin
        din = W'($urandom);
        din_valid = ($urandom_range(0, 9) < 6);
      end
      step();
    end
    din_valid = 1'b0;
    for (int i = 0; i < NB + 2; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_piso_sar.md
Name: seq_piso_sar

Overview:
- Parallel-in/serial-out stimulus stage that sits directly upstream of the 11011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB first, one bit per clock, on ser_out; ser_out drives the detector's serial input.
- Counts completed words modulo 10, matching the detector's decimal hit counter.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..15.
- IDLE_BIT, 1'b0, level driven on ser_out when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only on an accepted handshake.
- din_valid  input  1  upstream offers din.
- din_ready  output  1  block can accept din this cycle.
- ser_out  output  1  serial bit stream toward the detector.
- ser_valid  output  1  ser_out carries a data (or parity) bit this cycle.
- frame_done  output  1  one-cycle pulse in the cycle after the final bit of a word.
- word_cnt  output  4  completed-word count, 0..9, wraps.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state=IDLE, shift register=0, bit_cnt=0.
  - frame_done=0, word_cnt=0.
  - ser_valid=0, ser_out=IDLE_BIT.
  - din_ready=0 while reset is low; din_valid is ignored.
- States (one-hot, 2 bits): IDLE, SHIFT.
- Handshake:
  - A transfer occurs at a rising edge where din_valid&&din_ready.
  - din must be held stable while din_valid=1 and din_ready=0.
- IDLE:
  - din_ready=1, ser_valid=0, ser_out=IDLE_BIT.
  - On transfer: shreg<=din, bit_cnt<=NBITS-1, go to SHIFT.
- SHIFT:
  - ser_valid=1, ser_out=shreg[MSB] (combinational from the register).
  - Each edge: shreg<=shreg<<1 and bit_cnt<=bit_cnt-1.
- Last bit (SHIFT with bit_cnt==0):
  - din_ready=1.
  - If a transfer occurs, reload shreg and bit_cnt and stay in SHIFT. The next word's MSB follows with no gap.
  - Otherwise go to IDLE.
- Latency: a word accepted at edge N puts its MSB on ser_out in the cycle after edge N. Its last bit appears at cycle N+NBITS.
- Throughput: 1 word per NBITS cycles sustained. din_ready is low during all SHIFT cycles except the last bit.
- frame_done: registered. High for exactly one cycle after each last-bit cycle, including back-to-back words.
- word_cnt:
  - Increments on the same edge that sets frame_done.
  - 9 wraps to 0; it never shows a value above 9.
- NBITS = WIDTH (parity option off) or WIDTH+1 (parity option on). bit_cnt width is 4 bits.
- Reset asserted mid-word aborts the word immediately; no frame_done and no word_cnt increment occur for it.

Optional Feature:
- Macro: SEQ_PISO_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of din, computed at load) is appended after the LSB as slot NBITS-1, with ser_valid=1.
  - frame_done and word_cnt update after the parity slot.
  - Per-word latency grows by 1 cycle.
- Undefined: there is no parity logic; NBITS=WIDTH.

Decomposition:
- Package seq_det_pkg:
  - one-hot state encodings PISO_IDLE=2'b01, PISO_SHIFT=2'b10;
  - constant WORD_CNT_MAX=4'd9;
  - shared with the detector, which can reuse the decimal wrap constant.
- No sub-module: the shift register, down-counter and modulo-10 counter fit naturally in one module.

Test Plan:
- Reset check: hold reset low, toggle din_valid -> din_ready=0, ser_valid=0, ser_out=0, word_cnt=0. Release -> din_ready=1 in IDLE.
- Single word: din=8'b11011000, one-cycle valid -> ser_out 1,1,0,1,1,0,0,0 over 8 cycles with ser_valid=1. frame_done pulses in cycle 9, word_cnt=1, then IDLE.
- Back-to-back: din=8'hDB then 8'h1B, with valid held -> 16 contiguous ser_valid cycles with no gap. Two frame_done pulses 8 cycles apart; word_cnt=2.
- Wrap: 10 words of 8'hFF -> word_cnt steps 1..9 then 0 on the tenth frame_done.
- Mid-word reset: assert reset after 3 bits of 8'hA5 -> outputs go to reset values immediately. No frame_done; word_cnt=0.
- SEQ_PISO_PARITY_EN: din=8'b11011000 -> ninth bit 0 (even parity of four 1s). din=8'b11011001 -> ninth bit 1; frame_done in cycle 10.
